// File: rtl/alu_op_scheduler_if.sv
// alu_op_scheduler_if: request (req/req_ack with op and operands), response (rsp valid/ready, id, data, err) and datapath (alu_sel/a/b, alu_out) signals; slave = scheduler, master = requesters plus datapath
interface alu_op_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_ack;
  logic [2*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [3:0]        alu_sel;
  logic [7:0]        alu_out;
  logic              busy;
  modport master (
    output req, req_op, req_a, req_b, rsp_ready, alu_out,
    input  req_ack, rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy
  );
  modport slave (
    input  req, req_op, req_a, req_b, rsp_ready, alu_out,
    output req_ack, rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin share of a 2-cycle one-hot ALU among NREQ requesters; ports clk, rst (async active-low), bus (req/ack in, rsp valid/ready out, alu sel/operands out, alu_out in, busy)
module alu_op_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst,
  alu_op_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISS0, ISS1, CAPT, RESP} state_t;
  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] hi;
  logic [IDW-1:0] lo;
  logic           hi_vld;
  logic [IDW-1:0] gnt;
  logic           gnt_vld;
  logic [1:0]     g_op;
  logic [3:0]     g_a;
  logic [3:0]     g_b;
  logic           div0;
  always_comb begin
    hi_vld = 1'b0;
    hi = '0;
    lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) lo = IDW'(i);
      if (bus.req[i] && IDW'(i) >= ptr) begin
        hi_vld = 1'b1;
        hi = IDW'(i);
      end
    end
  end
  assign gnt_vld = |bus.req;
  assign gnt = hi_vld ? hi : lo;
  assign g_op = bus.req_op[{gnt, 1'b0} +: 2];
  assign g_a = bus.req_a[{gnt, 2'b00} +: 4];
  assign g_b = bus.req_b[{gnt, 2'b00} +: 4];
  assign div0 = g_op == 2'b10 && g_b == 4'd0;
  assign bus.req_ack = (rst && state == IDLE && gnt_vld) ? NREQ'(1) << gnt : '0;
  assign bus.rsp_id = id;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
      bus.alu_sel <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          id <= gnt;
          ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          bus.busy <= 1'b1;
          if (div0) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data <= 8'hFF;
            bus.rsp_err <= 1'b1;
          end else begin
            state <= ISS0;
            bus.alu_sel <= 4'b1000 >> g_op;
            bus.alu_a <= g_a;
            bus.alu_b <= g_b;
          end
        end
        ISS0: state <= ISS1;
        ISS1: begin
          state <= CAPT;
          bus.alu_sel <= '0;
          bus.alu_a <= '0;
          bus.alu_b <= '0;
        end
        CAPT: begin
          state <= RESP;
          bus.rsp_data <= bus.alu_out;
          bus.rsp_err <= 1'b0;
          bus.rsp_valid <= 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed vectors, corner sequences and randomized scoreboard check of alu_op_scheduler
module tb_alu_op_scheduler;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  alu_op_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  alu_op_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] ref_res(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0: return 8'(a) * 8'(b);
      2'd1: return 8'(a) + 8'(b);
      2'd2: return (b == 4'd0) ? 8'hFF : 8'(a / b);
      default: return 8'(a) - 8'(b);
    endcase
  endfunction
  function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      4'b1000: return 8'(a) * 8'(b);
      4'b0100: return 8'(a) + 8'(b);
      4'b0010: return (b == 4'd0) ? 8'h00 : 8'(a / b);
      4'b0001: return 8'(a) - 8'(b);
      default: return 8'h00;
    endcase
  endfunction
  logic [7:0] mid;
  logic [3:0] sel_q;
  always @(posedge clk) begin
    mid <= alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    sel_q <= bus.alu_sel;
    bus.alu_out <= (bus.alu_sel != 4'd0 && bus.alu_sel == sel_q) ? mid : 8'h00;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  int run = 0;
  always @(negedge clk) begin
    tests++;
    a_onehot: assert ($onehot0(bus.alu_sel)) else begin
      fails++;
      $display("FAIL sel_onehot: alu_sel=%b expected at most one bit", bus.alu_sel);
    end
    if (bus.alu_sel == 4'd0) chk("isolation", 32'({bus.alu_a, bus.alu_b}), 32'd0);
    if (!rst) run = 0;
    else if (bus.alu_sel != 4'd0) run++;
    else begin
      if (run != 0) chk("sel_len", run, 2);
      run = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.req[r] = 1'b1;
    bus.req_op[2*r +: 2] = op;
    bus.req_a[4*r +: 4] = a;
    bus.req_b[4*r +: 4] = b;
  endtask
  function automatic logic [31:0] all_outs();
    return 32'({bus.req_ack, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                bus.alu_a, bus.alu_b, bus.alu_sel, bus.busy});
  endfunction
  task automatic wait_ack(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        chk("ack_onehot", 32'($onehot(bus.req_ack)), 32'd1);
        for (int j = 0; j < NREQ; j++) if (bus.req_ack[j]) g = j;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    tick();
    rst = 1'b1;
  endtask
  typedef struct {
    int         r;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] d;
    logic       e;
  } vec_t;
  task automatic run_op(input vec_t v);
    tick();
    set_req(v.r, v.op, v.a, v.b);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("ack", 32'(bus.req_ack), 32'(1) << v.r);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.req[v.r] = 1'b0;
    if (v.e) begin
      @(negedge clk);
      chk("div0_valid", 32'(bus.rsp_valid), 32'd1);
      chk("div0_sel", 32'(bus.alu_sel), 32'd0);
    end else begin
      for (int c = 1; c <= 2; c++) begin
        @(negedge clk);
        chk("iss_sel", 32'(bus.alu_sel), 32'(4'b1000 >> v.op));
        chk("iss_opnd", 32'({bus.alu_a, bus.alu_b}), 32'({v.a, v.b}));
        chk("iss_valid", 32'(bus.rsp_valid), 32'd0);
      end
      @(negedge clk);
      chk("capt_sel", 32'(bus.alu_sel), 32'd0);
      chk("capt_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    chk("data", 32'(bus.rsp_data), 32'(v.d));
    chk("err", 32'(bus.rsp_err), 32'(v.e));
    chk("id", 32'(bus.rsp_id), v.r);
    chk("resp_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("busy_drop", 32'(bus.busy), 32'd0);
  endtask
  typedef struct {
    int         id;
    logic [7:0] d;
    logic       e;
    int         lat;
  } exp_t;
  exp_t q[$];
  vec_t tv[7];
  int exp4[4];
  int g;
  int mptr;
  int ack_cyc;
  bit outst;
  bit seen;
  bit [NREQ-1:0] acked;
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    do_reset();
    exp4 = '{2, 6, 4, 254};
    set_req(0, 2'd1, 4'd1, 4'd1);
    set_req(1, 2'd0, 4'd2, 4'd3);
    set_req(2, 2'd2, 4'd8, 4'd2);
    set_req(3, 2'd3, 4'd3, 4'd5);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(g);
      chk("rr_order", g, k % 4);
      if (k == 4) begin
        tick();
        bus.req = '0;
      end
      wait_valid();
      chk("rr_id", 32'(bus.rsp_id), k % 4);
      chk("rr_data", 32'(bus.rsp_data), exp4[k % 4]);
    end
    tv = '{'{0, 2'd1, 4'd3, 4'd5, 8'd8, 1'b0},
           '{2, 2'd0, 4'd15, 4'd15, 8'hE1, 1'b0},
           '{1, 2'd2, 4'd9, 4'd0, 8'hFF, 1'b1},
           '{3, 2'd3, 4'd3, 4'd5, 8'hFE, 1'b0},
           '{1, 2'd2, 4'd15, 4'd4, 8'd3, 1'b0},
           '{2, 2'd0, 4'd0, 4'd7, 8'd0, 1'b0},
           '{0, 2'd1, 4'd15, 4'd15, 8'd30, 1'b0}};
    for (int i = 0; i < 7; i++) run_op(tv[i]);
    tick();
    set_req(0, 2'd1, 4'd2, 4'd2);
    bus.rsp_ready = 1'b0;
    wait_ack(g);
    chk("stall_ack", g, 0);
    tick();
    bus.req[0] = 1'b0;
    set_req(1, 2'd0, 4'd3, 4'd3);
    wait_valid();
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_data", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 32'({2'd0, 1'b0, 8'd4}));
      chk("stall_noack", 32'(bus.req_ack), 32'd0);
      chk("stall_busy", 32'(bus.busy), 32'd1);
    end
    tick();
    bus.rsp_ready = 1'b1;
    wait_ack(g);
    chk("after_stall_ack", g, 1);
    tick();
    bus.req[1] = 1'b0;
    wait_valid();
    chk("after_stall_data", 32'({bus.rsp_id, bus.rsp_data}), 32'({2'd1, 8'd9}));
    tick();
    set_req(2, 2'd3, 4'd9, 4'd4);
    wait_ack(g);
    chk("rst_first_ack", g, 2);
    tick();
    bus.req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_iss1_sel", 32'(bus.alu_sel), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 32'd0);
    @(negedge clk);
    chk("rst_edge_outs", all_outs(), 32'd0);
    tick();
    set_req(2, 2'd3, 4'd9, 4'd4);
    rst = 1'b1;
    wait_ack(g);
    chk("rst_reack", g, 2);
    tick();
    bus.req[2] = 1'b0;
    wait_valid();
    chk("rst_redo_data", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 32'({2'd2, 1'b0, 8'd5}));
    tick();
    bus.rsp_ready = 1'b0;
    do_reset();
    mptr = 0;
    outst = 1'b0;
    seen = 1'b0;
    acked = '0;
    ack_cyc = 0;
    for (int n = 0; n < 2030; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (n >= 2000 || acked[i]) begin
          bus.req[i] = 1'b0;
          acked[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 2'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom));
        else if (bus.req[i] && $urandom_range(0, 59) == 0)
          bus.req[i] = 1'b0;
      end
      bus.rsp_ready = (n >= 2000) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      g = -1;
      if (!outst) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && bus.req[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
        end
      end
      chk("rand_ack", 32'(bus.req_ack), (g >= 0) ? 32'(1) << g : 32'd0);
      if (g >= 0) begin
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       e;
        op = bus.req_op[2*g +: 2];
        a = bus.req_a[4*g +: 4];
        b = bus.req_b[4*g +: 4];
        e = (op == 2'd2 && b == 4'd0);
        q.push_back('{g, ref_res(op, a, b), e, e ? 1 : 4});
        outst = 1'b1;
        mptr = (g + 1) % NREQ;
        acked[g] = 1'b1;
        ack_cyc = cyc;
        seen = 1'b0;
      end
      if (bus.rsp_valid) begin
        chk("rand_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          if (!seen) chk("rand_latency", cyc - ack_cyc, q[0].lat);
          seen = 1'b1;
          chk("rand_id", 32'(bus.rsp_id), q[0].id);
          chk("rand_data", 32'(bus.rsp_data), 32'(q[0].d));
          chk("rand_err", 32'(bus.rsp_err), 32'(q[0].e));
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            outst = 1'b0;
          end
        end
      end
    end
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
